// File: rtl/polilock_controle_param_if.sv
// rtl/polilock_controle_param_if.sv - user/memory side signal bundle of the lock controller
// Ports (master = user + password memory, slave = controller):
//   iniciar, funcao_selecionada, funcao, slot, digito_valido, digito, mem_dado  : master -> slave
//   mem_end, mem_escreve, mem_dado_esc, acertou, errou, bloqueado,
//   tentativas_rest, db_estado                                                 : slave -> master
interface polilock_controle_param_if #(
    parameter int DIGIT_W = 4,
    parameter int SLOT_W  = 1,
    parameter int IDX_W   = 2,
    parameter int TENT_W  = 2
);
    logic                      iniciar;
    logic                      funcao_selecionada;
    logic [1:0]                funcao;
    logic [SLOT_W-1:0]         slot;
    logic                      digito_valido;
    logic [DIGIT_W-1:0]        digito;
    logic [DIGIT_W-1:0]        mem_dado;
    logic [SLOT_W+IDX_W-1:0]   mem_end;
    logic                      mem_escreve;
    logic [DIGIT_W-1:0]        mem_dado_esc;
    logic                      acertou;
    logic                      errou;
    logic                      bloqueado;
    logic [TENT_W-1:0]         tentativas_rest;
    logic [3:0]                db_estado;

    modport master (
        output iniciar, funcao_selecionada, funcao, slot, digito_valido, digito, mem_dado,
        input  mem_end, mem_escreve, mem_dado_esc, acertou, errou, bloqueado,
               tentativas_rest, db_estado
    );

    modport slave (
        input  iniciar, funcao_selecionada, funcao, slot, digito_valido, digito, mem_dado,
        output mem_end, mem_escreve, mem_dado_esc, acertou, errou, bloqueado,
               tentativas_rest, db_estado
    );
endinterface

// File: rtl/polilock_controle_param.sv
// rtl/polilock_controle_param.sv - multi-slot password lock controller with attempt lockout
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : polilock_controle_param_if.slave (user entry, password memory, status outputs)
module polilock_controle_param #(
    parameter int PWD_LEN     = 4,
    parameter int DIGIT_W     = 4,
    parameter int N_SLOTS     = 2,
    parameter int MAX_TENT    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    polilock_controle_param_if.slave bus
);
    localparam int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int IDX_W   = (PWD_LEN > 1) ? $clog2(PWD_LEN) : 1;
    localparam int TENT_W  = $clog2(MAX_TENT + 1);
    localparam int TIMER_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [3:0] S_INICIAL        = 4'h0;
    localparam logic [3:0] S_PREPARACAO     = 4'h1;
    localparam logic [3:0] S_ESPERA_FUNCAO  = 4'h2;
    localparam logic [3:0] S_ESCOLHE_FUNCAO = 4'h3;
    localparam logic [3:0] S_ESPERA_DIGITO  = 4'h4;
    localparam logic [3:0] S_ESPERA_MEM     = 4'h5;
    localparam logic [3:0] S_COMPARA        = 4'h6;
    localparam logic [3:0] S_AVALIA         = 4'h7;
    localparam logic [3:0] S_GANHOU         = 4'h8;
    localparam logic [3:0] S_PERDEU         = 4'h9;
    localparam logic [3:0] S_BLOQUEADO      = 4'hA;
    localparam logic [3:0] S_GRAVA          = 4'hB;

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(PWD_LEN - 1);
    localparam logic [TENT_W-1:0]  TENT_MAX   = TENT_W'(MAX_TENT);
    // With LOCK_CYCLES == 0 the timer is never consulted; load 0 to keep the value in range.
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'((LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0);

    logic [3:0]         state, next_state;
    logic [IDX_W-1:0]   idx;
    logic [TENT_W-1:0]  tent;
    logic [TIMER_W-1:0] timer;
    logic               mismatch;
    logic [SLOT_W-1:0]  slot_reg;
    logic [DIGIT_W-1:0] dig_reg;
    logic [1:0]         mode;

    wire idx_last = (idx == IDX_LAST);

    always_comb begin
        next_state = state;
        case (state)
            S_INICIAL:        if (bus.iniciar) next_state = S_PREPARACAO;
            S_PREPARACAO:     next_state = S_ESPERA_FUNCAO;
            S_ESPERA_FUNCAO:  if (bus.funcao_selecionada) next_state = S_ESCOLHE_FUNCAO;
            S_ESCOLHE_FUNCAO: next_state = (mode == 2'b01 || mode == 2'b10) ? S_ESPERA_DIGITO
                                                                             : S_ESPERA_FUNCAO;
            S_ESPERA_DIGITO:  if (bus.digito_valido)
                                  next_state = (mode == 2'b10) ? S_GRAVA : S_ESPERA_MEM;
            S_ESPERA_MEM:     next_state = S_COMPARA;
            S_COMPARA:        next_state = idx_last ? S_AVALIA : S_ESPERA_DIGITO;
            S_AVALIA:         next_state = mismatch ? S_PERDEU : S_GANHOU;
            S_GANHOU:         if (bus.iniciar) next_state = S_PREPARACAO;
            S_PERDEU:         if (tent == TENT_MAX) next_state = S_BLOQUEADO;
                              else if (bus.iniciar) next_state = S_PREPARACAO;
            S_BLOQUEADO:      if (LOCK_CYCLES != 0 && timer == '0) next_state = S_INICIAL;
            S_GRAVA:          next_state = idx_last ? S_PREPARACAO : S_ESPERA_DIGITO;
            default:          next_state = S_INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_INICIAL;
            idx      <= '0;
            tent     <= '0;
            timer    <= '0;
            mismatch <= 1'b0;
            slot_reg <= '0;
            dig_reg  <= '0;
            mode     <= 2'b00;
        end else begin
            state <= next_state;
            case (state)
                S_PREPARACAO: begin
                    idx      <= '0;
                    mismatch <= 1'b0;
                end
                S_ESPERA_FUNCAO: if (bus.funcao_selecionada) begin
                    slot_reg <= bus.slot;
                    mode     <= bus.funcao;
                end
                S_ESPERA_DIGITO: if (bus.digito_valido) dig_reg <= bus.digito;
                S_COMPARA: begin
                    // Sticky flag: a wrong digit never shortens entry, so timing reveals nothing.
                    if (dig_reg != bus.mem_dado) mismatch <= 1'b1;
                    if (!idx_last) idx <= idx + 1'b1;
                end
                S_AVALIA: begin
                    if (!mismatch)              tent <= '0;
                    else if (tent != TENT_MAX)  tent <= tent + 1'b1;
                end
                S_PERDEU: if (tent == TENT_MAX) timer <= TIMER_LOAD;
                S_BLOQUEADO: if (LOCK_CYCLES != 0) begin
                    if (timer == '0) tent  <= '0;
                    else             timer <= timer - 1'b1;
                end
                S_GRAVA: if (!idx_last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.db_estado = state;
        if (state > S_GRAVA) bus.db_estado = 4'hF;
    end

    assign bus.mem_end         = {slot_reg, idx};
    assign bus.mem_dado_esc    = dig_reg;
    assign bus.mem_escreve     = (state == S_GRAVA);
    assign bus.acertou         = (state == S_GANHOU);
    assign bus.errou           = (state == S_PERDEU);
    assign bus.bloqueado       = (state == S_BLOQUEADO);
    assign bus.tentativas_rest = TENT_MAX - tent;
endmodule

// File: tb/tb_polilock_controle_param.sv
// tb/tb_polilock_controle_param.sv - directed self-checking bench for polilock_controle_param
module tb_polilock_controle_param;
    localparam int DIGIT_W = 4;
    localparam int SLOT_W  = 1;
    localparam int IDX_W   = 2;
    localparam int TENT_W  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [DIGIT_W-1:0] mem [0:7];
    int wr_addr[$];
    int wr_data[$];

    polilock_controle_param_if #(
        .DIGIT_W(DIGIT_W), .SLOT_W(SLOT_W), .IDX_W(IDX_W), .TENT_W(TENT_W)
    ) bus ();

    polilock_controle_param #(
        .PWD_LEN(4), .DIGIT_W(DIGIT_W), .N_SLOTS(2), .MAX_TENT(3), .LOCK_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Password memory: one-cycle synchronous read, synchronous write.
    always @(posedge clock) begin
        bus.mem_dado <= mem[bus.mem_end];
        if (bus.mem_escreve) mem[bus.mem_end] <= bus.mem_dado_esc;
    end

    always @(negedge clock) begin
        if (bus.mem_escreve && !reset) begin
            wr_addr.push_back(int'(bus.mem_end));
            wr_data.push_back(int'(bus.mem_dado_esc));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_state(input string tag, input int code, input int max_cycles);
        int n = 0;
        while (int'(bus.db_estado) != code && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check(tag, int'(bus.db_estado), code);
    endtask

    task automatic start();
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
    endtask

    task automatic select_func(input logic [1:0] f, input logic [SLOT_W-1:0] s);
        wait_state("wait_espera_funcao", 2, 20);
        bus.funcao_selecionada = 1'b1;
        bus.funcao = f;
        bus.slot = s;
        @(negedge clock);
        bus.funcao_selecionada = 1'b0;
    endtask

    task automatic send_digit(input logic [DIGIT_W-1:0] d, input int hold);
        wait_state("wait_espera_digito", 4, 20);
        bus.digito_valido = 1'b1;
        bus.digito = d;
        repeat (hold) @(negedge clock);
        bus.digito_valido = 1'b0;
    endtask

    task automatic wrong_attempt(input int exp_rest);
        select_func(2'b01, 1'b1);
        send_digit(4'd9, 1);
        send_digit(4'd1, 1);
        send_digit(4'd4, 1);
        send_digit(4'd1, 1);
        wait_state("perdeu", 9, 20);
        check("errou_wrong", int'(bus.errou), 1);
        check("rest_wrong", int'(bus.tentativas_rest), exp_rest);
    endtask

    initial begin
        int cnt;
        int n;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        bus.iniciar = 1'b0;
        bus.funcao_selecionada = 1'b0;
        bus.funcao = 2'b00;
        bus.slot = '0;
        bus.digito_valido = 1'b0;
        bus.digito = '0;

        repeat (2) @(negedge clock);
        check("rst_db_estado", int'(bus.db_estado), 0);
        check("rst_rest", int'(bus.tentativas_rest), 3);
        check("rst_acertou", int'(bus.acertou), 0);
        check("rst_errou", int'(bus.errou), 0);
        check("rst_bloqueado", int'(bus.bloqueado), 0);
        check("rst_mem_escreve", int'(bus.mem_escreve), 0);
        check("rst_mem_end", int'(bus.mem_end), 0);
        reset = 1'b0;
        @(negedge clock);

        // Ignored iniciar-less wait, then start.
        check("idle_inicial", int'(bus.db_estado), 0);
        start();
        check("preparacao", int'(bus.db_estado), 1);

        // Configure slot 1 with 3,1,4,1.
        select_func(2'b10, 1'b1);
        send_digit(4'd3, 1);
        send_digit(4'd1, 1);
        send_digit(4'd4, 1);
        send_digit(4'd1, 1);
        check("cfg_last_grava", int'(bus.db_estado), 11);
        @(negedge clock);
        check("cfg_to_prep", int'(bus.db_estado), 1);
        @(negedge clock);
        check("cfg_to_espera_funcao", int'(bus.db_estado), 2);
        check("cfg_write_count", wr_addr.size(), 4);
        if (wr_addr.size() == 4) begin
            check("cfg_addr0", wr_addr[0], 4);
            check("cfg_addr1", wr_addr[1], 5);
            check("cfg_addr2", wr_addr[2], 6);
            check("cfg_addr3", wr_addr[3], 7);
            check("cfg_data0", wr_data[0], 3);
            check("cfg_data1", wr_data[1], 1);
            check("cfg_data2", wr_data[2], 4);
            check("cfg_data3", wr_data[3], 1);
        end

        // Correct verify.
        select_func(2'b01, 1'b1);
        send_digit(4'd3, 1);
        send_digit(4'd1, 1);
        send_digit(4'd4, 1);
        send_digit(4'd1, 1);
        wait_state("ganhou", 8, 20);
        check("acertou", int'(bus.acertou), 1);
        check("rest_ok", int'(bus.tentativas_rest), 3);
        start();
        check("ganhou_restart", int'(bus.db_estado), 1);

        // Wrong verify; first strobe held through ESPERA_MEM and COMPARA.
        select_func(2'b01, 1'b1);
        send_digit(4'd9, 3);
        check("hold_state", int'(bus.db_estado), 4);
        check("hold_idx_once", int'(bus.mem_end), 5);
        send_digit(4'd1, 1);
        send_digit(4'd4, 1);
        check("no_early_errou", int'(bus.errou), 0);
        send_digit(4'd1, 1);
        wait_state("perdeu1", 9, 20);
        check("errou1", int'(bus.errou), 1);
        check("rest1", int'(bus.tentativas_rest), 2);
        check("wrong_no_writes", wr_addr.size(), 4);

        start();
        wrong_attempt(1);
        start();
        wrong_attempt(0);

        // Lockout: count BLOQUEADO cycles while strobing digits.
        cnt = 0;
        n = 0;
        @(negedge clock);
        while (n < 40) begin
            if (bus.bloqueado) cnt++;
            else if (cnt > 0) break;
            bus.digito_valido = n[0];
            bus.digito = 4'(n);
            bus.iniciar = n[1];
            @(negedge clock);
            n++;
        end
        bus.digito_valido = 1'b0;
        bus.iniciar = 1'b0;
        check("lock_cycles", cnt, 8);
        check("after_lock_state", int'(bus.db_estado), 0);
        check("after_lock_rest", int'(bus.tentativas_rest), 3);

        // Invalid function code.
        start();
        select_func(2'b11, 1'b0);
        check("escolhe_funcao", int'(bus.db_estado), 3);
        @(negedge clock);
        check("invalid_func_back", int'(bus.db_estado), 2);

        // Reset in the middle of a write.
        select_func(2'b10, 1'b0);
        send_digit(4'd7, 1);
        check("grava_active", int'(bus.mem_escreve), 1);
        #1 reset = 1'b1;
        #1;
        check("rst_grava_we", int'(bus.mem_escreve), 0);
        check("rst_grava_state", int'(bus.db_estado), 0);
        check("rst_grava_rest", int'(bus.tentativas_rest), 3);
        check("rst_grava_end", int'(bus.mem_end), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_grava_no_write", int'(mem[0]), 0);
        check("rst_grava_idle", int'(bus.db_estado), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/polilock_controle_param.md
POLILOCK_CONTROLE_PARAM -- requirements
Module: polilock_controle_param

Interface
REQ-001 SHALL have parameter PWD_LEN, default 4: digits per password.
REQ-002 SHALL have parameter DIGIT_W, default 4: bits per digit.
REQ-003 SHALL have parameter N_SLOTS, default 2: independent password slots. SLOT_W = max(1, clog2(N_SLOTS)). IDX_W = max(1, clog2(PWD_LEN)).
REQ-004 SHALL have parameter MAX_TENT, default 3: failed attempts before lockout. TENT_W = clog2(MAX_TENT+1).
REQ-005 SHALL have parameter LOCK_CYCLES, default 1000: lockout duration in clocks. Value 0 makes lockout permanent until reset.
REQ-006 SHALL have the following ports:
  - clock  in  1  rising-edge clock
  - reset  in  1  reset, asynchronous, active-high
  - iniciar  in  1  start/restart request
  - funcao_selecionada  in  1  funcao and slot are valid
  - funcao  in  2  01 = verify, 10 = configure, other values invalid
  - slot  in  SLOT_W  password slot select
  - digito_valido  in  1  one-cycle strobe: digito is valid
  - digito  in  DIGIT_W  entered digit
  - mem_dado  in  DIGIT_W  memory read data, 1-cycle synchronous read
  - mem_end  out  SLOT_W+IDX_W  memory address {slot_reg, idx}
  - mem_escreve  out  1  memory write enable
  - mem_dado_esc  out  DIGIT_W  memory write data
  - acertou  out  1  password accepted
  - errou  out  1  password rejected
  - bloqueado  out  1  lockout active
  - tentativas_rest  out  TENT_W  attempts remaining
  - db_estado  out  4  current state code

Function
REQ-007 SHALL implement a Moore FSM with the following state codes: INICIAL=0, PREPARACAO=1, ESPERA_FUNCAO=2, ESCOLHE_FUNCAO=3, ESPERA_DIGITO=4, ESPERA_MEM=5, COMPARA=6, AVALIA=7, GANHOU=8, PERDEU=9, BLOQUEADO=A, GRAVA=B. db_estado SHALL equal the state code; any unused encoding SHALL show F on db_estado and go to INICIAL on the next clock.
REQ-008 SHALL use the following transitions:
  - INICIAL: to PREPARACAO when iniciar=1.
  - PREPARACAO: clear idx and mismatch flag; to ESPERA_FUNCAO.
  - ESPERA_FUNCAO: to ESCOLHE_FUNCAO when funcao_selecionada=1; latch slot into slot_reg and funcao into mode.
  - ESCOLHE_FUNCAO: to ESPERA_DIGITO for 01 or 10; otherwise back to ESPERA_FUNCAO.
  - ESPERA_DIGITO: on digito_valido, latch digito into dig_reg; verify mode goes to ESPERA_MEM, configure mode goes to GRAVA.
REQ-009 Verify path SHALL work as follows:
  - ESPERA_MEM lasts exactly 1 cycle, then COMPARA.
  - COMPARA sets the mismatch flag if dig_reg != mem_dado. The flag is sticky, so all PWD_LEN digits are always collected.
  - If idx == PWD_LEN-1, go to AVALIA; otherwise idx increments and the FSM returns to ESPERA_DIGITO.
REQ-010 AVALIA SHALL go to PERDEU with tent incremented (saturating at MAX_TENT) if the mismatch flag is set; otherwise to GANHOU with tent cleared.
REQ-011 GANHOU SHALL hold until iniciar=1, then go to PREPARACAO.
REQ-012 PERDEU behaviour:
  - If tent == MAX_TENT, go to BLOQUEADO on the next clock and load the timer with LOCK_CYCLES-1.
  - Otherwise hold until iniciar=1, then go to PREPARACAO.
REQ-013 BLOQUEADO behaviour:
  - Ignore all inputs.
  - When LOCK_CYCLES>0: decrement the timer each cycle; at timer==0, clear tent and go to INICIAL. Lockout therefore lasts exactly LOCK_CYCLES cycles.
  - When LOCK_CYCLES=0: stay in BLOQUEADO until reset.
REQ-014 GRAVA SHALL assert mem_escreve for exactly 1 cycle with mem_dado_esc=dig_reg and mem_end={slot_reg, idx}. If idx == PWD_LEN-1, go to PREPARACAO; otherwise increment idx and go to ESPERA_DIGITO.
REQ-015 mem_end SHALL always equal {slot_reg, idx}.
REQ-016 Decoded outputs:
  - acertou=1 only in GANHOU.
  - errou=1 only in PERDEU.
  - bloqueado=1 only in BLOQUEADO.
  - mem_escreve=1 only in GRAVA.
  - tentativas_rest = MAX_TENT - tent.
REQ-017 digito_valido SHALL be ignored outside ESPERA_DIGITO. iniciar and funcao_selecionada SHALL be ignored outside the states that consume them.
REQ-018 The failed-attempt count SHALL be global across all slots.

Reset
REQ-019 Asserting reset SHALL immediately force:
  - state INICIAL;
  - idx, tent, timer, mismatch flag, slot_reg, dig_reg and mode to 0;
  - every output to 0, except tentativas_rest=MAX_TENT and db_estado=0.
REQ-020 Reset during BLOQUEADO or GRAVA SHALL abort the operation with no further write; the attempt count is cleared.

Verification
REQ-021 Configure slot 1 with digits 3,1,4,1 -> exactly four mem_escreve pulses at addresses 4,5,6,7 carrying data 3,1,4,1; FSM returns to ESPERA_FUNCAO via PREPARACAO.
REQ-022 Verify slot 1 with 3,1,4,1 -> acertou=1 and tentativas_rest=3; iniciar -> db_estado=1.
REQ-023 Verify with 9,1,4,1 -> FSM still waits for all 4 digits; errou=1 only after the 4th digit; tentativas_rest=2.
REQ-024 Three wrong entries with LOCK_CYCLES=8 -> bloqueado=1 for exactly 8 cycles, then INICIAL with tentativas_rest=3; digit strobes during lockout have no effect.
REQ-025 funcao=11 -> FSM returns to ESPERA_FUNCAO; reset asserted mid-GRAVA -> mem_escreve drops immediately and state is INICIAL.
REQ-026 digito_valido asserted in ESPERA_MEM or COMPARA -> ignored; idx advances only once per accepted digit.
